// File: rtl/mem_responder.sv
// mem_responder: MAR/MDR owner and word-addressed RAM with a fixed number of
// wait states per access and a one-cycle Mem_Ready completion pulse.
// Optional feature macro: MEM_RANGE_CHECK_EN. When it is defined, accesses
// with nonzero MAR bits above the RAM index are flagged on Mem_Err. Such
// writes are dropped, and such reads return 0.
module mem_responder #(
    parameter int ADDR_BITS   = 9,
    parameter int DEPTH       = 512,
    parameter int WAIT_STATES = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] BusMuxOut,
    input  logic        MARin,
    input  logic        MDRin,
    input  logic        Read,
    input  logic        Write,
    output logic [31:0] MAR_q,
    output logic [31:0] MDR_q,
    output logic        Mem_Ready,
    output logic        Mem_Err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                 state_reg, state_next;
    logic [31:0]            mar_reg;
    logic [31:0]            mdr_reg;
    logic [31:0]            data_l_reg;
    logic [ADDR_BITS-1:0]   addr_l_reg;
    logic [3:0]             cnt_reg;
    logic                   is_write_reg;
    logic                   range_err;

    // Decoded control strobes, produced by the FSM output process
    logic                   accept;
    logic                   accept_write;
    logic                   finish;
    logic                   mdr_load_en;
    logic                   mem_we;

    logic [31:0]            mem [DEPTH];

`ifdef MEM_RANGE_CHECK_EN
    logic                   range_err_reg;

    // Capture the out-of-range status of the address with the access itself
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            range_err_reg <= 1'b0;
        end else if (accept) begin
            range_err_reg <= (mar_reg[31:ADDR_BITS] != '0);
        end
    end

    assign range_err = range_err_reg;
`else
    // Upper address bits are ignored: addresses wrap modulo DEPTH
    assign range_err = 1'b0;
`endif

    // State register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; RELEASE blocks a held strobe from re-triggering
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (Read || Write) state_next = BUSY;
            BUSY:    if (cnt_reg == 4'd0) state_next = DONE;
            DONE:    state_next = RELEASE;
            RELEASE: if (!Read && !Write) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output and control decode from the current state
    always_comb begin
        accept       = (state_reg == IDLE) && (Read || Write);
        accept_write = (state_reg == IDLE) && !Read && Write;
        finish       = (state_reg == BUSY) && (cnt_reg == 4'd0);
        mdr_load_en  = MDRin && (state_reg != BUSY);
        mem_we       = finish && is_write_reg && !range_err;
        Mem_Ready    = (state_reg == DONE);
        Mem_Err      = (state_reg == DONE) && range_err;
    end

    // Access bookkeeping: latched address/data, direction and wait counter
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            addr_l_reg   <= '0;
            data_l_reg   <= '0;
            is_write_reg <= 1'b0;
            cnt_reg      <= 4'd0;
        end else begin
            if (accept) begin
                addr_l_reg   <= mar_reg[ADDR_BITS-1:0];
                is_write_reg <= accept_write;
                cnt_reg      <= 4'(WAIT_STATES);
            end else if ((state_reg == BUSY) && (cnt_reg != 4'd0)) begin
                cnt_reg <= cnt_reg - 4'd1;
            end
            if (accept_write) begin
                data_l_reg <= mdr_reg;
            end
        end
    end

    // MAR loads in any state; MDR takes read results over CPU-side loads
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            mar_reg <= '0;
            mdr_reg <= '0;
        end else begin
            if (MARin) begin
                mar_reg <= BusMuxOut;
            end
            if (finish && !is_write_reg) begin
                mdr_reg <= range_err ? 32'd0 : mem[addr_l_reg];
            end else if (mdr_load_en) begin
                mdr_reg <= BusMuxOut;
            end
        end
    end

    // RAM write port; contents are deliberately not reset
    always_ff @(posedge Clock) begin
        if (mem_we) begin
            mem[addr_l_reg] <= data_l_reg;
        end
    end

    assign MAR_q = mar_reg;
    assign MDR_q = mdr_reg;

endmodule
